// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide unit.
// Op codes follow the RV32M funct3 encoding.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DIV0_QUO = '1;
    localparam logic [XLEN-1:0] OVF_QUO  = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-side request/result bundle between the pipeline and ex_muldiv.
// The master is the pipeline; the slave is the muldiv unit.
interface ex_muldiv_if #(
    parameter int size = 32
);
    logic            start;
    logic [2:0]      op;
    logic [size-1:0] rs1;
    logic [size-1:0] rs2;
    logic [4:0]      rd_in;
    logic            kill;
    logic            busy;
    logic            stall;
    logic            valid;
    logic [size-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, op, rs1, rs2, rd_in, kill,
        input  busy, stall, valid, result, rd_out
    );

    modport slave (
        input  start, op, rs1, rs2, rd_in, kill,
        output busy, stall, valid, result, rd_out
    );
endinterface

// File: rtl/ex_muldiv_sign.sv
// Sign handling around the unsigned muldiv core: operand magnitudes on
// entry, conditional two's complement of the raw result on exit.
module muldiv_sign
    import muldiv_pkg::*;
#(
    parameter int size = 32
) (
    input  muldiv_op_t        op,
    input  logic [size-1:0]   rs1,
    input  logic [size-1:0]   rs2,
    output logic [size-1:0]   a_mag,
    output logic [size-1:0]   b_mag,
    output logic              neg_q,
    output logic              neg_r,
    input  logic [2*size-1:0] raw,
    input  logic              raw_neg,
    output logic [2*size-1:0] fixed
);
    logic a_sgn, b_sgn, sa, sb;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            OP_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign sa    = a_sgn & rs1[size-1];
    assign sb    = b_sgn & rs2[size-1];
    assign a_mag = sa ? -rs1 : rs1;
    assign b_mag = sb ? -rs2 : rs2;
    assign neg_q = sa ^ sb;
    assign neg_r = sa;
    assign fixed = raw_neg ? -raw : raw;
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide for the EX stage: radix-2 shift-add
// multiply and restoring divide, one bit per cycle, stalling the front end.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int size = 32
) (
    input logic   CLK,
    input logic   RESET_N,
    ex_muldiv_if.slave bus
);
    localparam int N  = size;
    localparam int CW = $clog2(size);
    localparam logic [N-1:0] Q_DIV0 = N'(DIV0_QUO);
    localparam logic [N-1:0] Q_OVF  = N'(OVF_QUO);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  prod_q, prod_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [N-1:0]    mcand_q, mcand_d;
    muldiv_op_t      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            nq_q, nq_d;
    logic            nr_q, nr_d;

    muldiv_op_t      op_in;
    logic [N-1:0]    a_mag, b_mag;
    logic            neg_q, neg_r;
    logic [2*N-1:0]  raw, fixed;
    logic            raw_neg, is_rem, go, div0, ovf, ge;
    logic [N:0]      sum, r_sh;

    assign op_in = muldiv_op_t'(bus.op);
    assign go    = bus.start & ~bus.kill;
    assign div0  = bus.rs2 == '0;
    assign ovf   = (op_in == OP_DIV || op_in == OP_REM)
                 && bus.rs1 == Q_OVF && bus.rs2 == '1;

    muldiv_sign #(.size(N)) u_sign (
        .op      (op_in),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .neg_q   (neg_q),
        .neg_r   (neg_r),
        .raw     (raw),
        .raw_neg (raw_neg),
        .fixed   (fixed)
    );

    // mcand_q doubles as the divisor; prod_q low half holds the quotient
    assign sum  = {1'b0, prod_q[2*N-1:N]}
                + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign r_sh = {rem_q, prod_q[N-1]};
    assign ge   = r_sh >= {1'b0, mcand_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        mcand_d = mcand_q;
        op_d    = op_q;
        rd_d    = rd_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        unique case (state_q)
            IDLE: if (go) begin
                op_d    = op_in;
                rd_d    = bus.rd_in;
                cnt_d   = CW'(N - 1);
                mcand_d = op_in[2] ? b_mag : a_mag;
                prod_d  = {{N{1'b0}}, op_in[2] ? a_mag : b_mag};
                rem_d   = '0;
                nq_d    = neg_q;
                nr_d    = neg_r;
                state_d = op_in[2] ? DIV : MUL;
                if (op_in[2] && (div0 || ovf)) begin
                    prod_d  = {{N{1'b0}}, div0 ? Q_DIV0 : Q_OVF};
                    rem_d   = div0 ? bus.rs1 : '0;
                    nq_d    = 1'b0;
                    nr_d    = 1'b0;
                    state_d = DONE;
                end
            end
            MUL: begin
                prod_d  = {sum, prod_q[N-1:1]};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = DONE;
                if (bus.kill) state_d = IDLE;
            end
            DIV: begin
                prod_d  = {prod_q[2*N-1:N], prod_q[N-2:0], ge};
                rem_d   = ge ? r_sh[N-1:0] - mcand_q : r_sh[N-1:0];
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = DONE;
                if (bus.kill) state_d = IDLE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            mcand_q <= '0;
            op_q    <= OP_MUL;
            rd_q    <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            mcand_q <= mcand_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
        end
    end

    assign is_rem  = (op_q == OP_REM) || (op_q == OP_REMU);
    assign raw     = op_q[2]
                   ? {{N{1'b0}}, is_rem ? rem_q : prod_q[N-1:0]}
                   : prod_q;
    assign raw_neg = is_rem ? nr_q : nq_q;

    assign bus.busy   = state_q != IDLE;
    assign bus.stall  = (state_q == IDLE && go)
                      || state_q == MUL || state_q == DIV;
    assign bus.valid  = state_q == DONE && !bus.kill;
    assign bus.rd_out = rd_q;
    assign bus.result = (state_q != DONE) ? '0
                      : (op_q == OP_MUL || op_q[2]) ? fixed[N-1:0]
                      : fixed[2*N-1:N];
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: results queued at issue, popped on valid.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    localparam int N = 32;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [N-1:0] exp_q[$];
    logic [4:0]   exprd_q[$];

    ex_muldiv_if #(.size(N)) bus();

    ex_muldiv #(.size(N)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] res,
                          input int lat, input logic [4:0] rd);
        int cyc;
        int stall_lo;
        bit seen;
        logic [N-1:0] e;
        logic [4:0] er;
        @(negedge CLK);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.rd_in = rd;
        exp_q.push_back(res);
        exprd_q.push_back(rd);
        #1 chk("stall_c0", 64'(bus.stall), 64'd1);
        cyc = 0;
        stall_lo = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (bus.valid) seen = 1'b1;
            else if (!bus.stall) stall_lo++;
        end
        e  = exp_q.pop_front();
        er = exprd_q.pop_front();
        chk("latency", seen ? 64'(cyc) : 64'hDEAD, 64'(lat));
        if (seen) begin
            chk("stall_done", 64'(bus.stall), 64'd0);
            chk("stall_busy", 64'(stall_lo), 64'd0);
            chk("result", 64'(bus.result), 64'(e));
            chk("rd_out", 64'(bus.rd_out), 64'(er));
        end
        @(negedge CLK);
        bus.start = 1'b0;
        @(posedge CLK);
        #1 chk("valid_1cyc", 64'(bus.valid), 64'd0);
    endtask

    initial begin
        int nv;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        bus.rd_in = '0;
        bus.kill  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_rd", 64'(bus.rd_out), 64'd0);
        @(negedge CLK) RESET_N = 1'b1;

        run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 5'd1);
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 5'd2);
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 5'd3);
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 5'd4);
        run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 5'd5);
        run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 5'd6);
        run_op(OP_DIVU,   32'd100,       32'd7,         32'd14,        33, 5'd7);
        run_op(OP_REMU,   32'd100,       32'd7,         32'd2,         33, 5'd8);
        run_op(OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  5'd9);
        run_op(OP_REM,    32'd5,         32'd0,         32'd5,         1,  5'd10);
        run_op(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  5'd11);
        run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  5'd12);
        run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  5'd13);
        run_op(OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 5'd14);

        // flush a divide in flight
        @(negedge CLK);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        bus.rd_in = 5'd15;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        bus.kill  = 1'b1;
        bus.start = 1'b0;
        #1 chk("kill_valid", 64'(bus.valid), 64'd0);
        @(posedge CLK);
        #1;
        chk("kill_busy", 64'(bus.busy), 64'd0);
        chk("kill_stall", 64'(bus.stall), 64'd0);
        @(negedge CLK) bus.kill = 1'b0;
        nv = 0;
        repeat (40) begin
            @(posedge CLK);
            #1 if (bus.valid) nv++;
        end
        chk("kill_novalid", 64'(nv), 64'd0);
        run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 33, 5'd16);

        // asynchronous reset mid-multiply
        @(negedge CLK);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.rs1   = 32'd5;
        bus.rs2   = 32'd6;
        bus.rd_in = 5'd17;
        repeat (5) @(posedge CLK);
        #2 chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        RESET_N   = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_stall", 64'(bus.stall), 64'd0);
        chk("arst_valid", 64'(bus.valid), 64'd0);
        chk("arst_result", 64'(bus.result), 64'd0);
        chk("arst_rd", 64'(bus.rd_out), 64'd0);
        @(negedge CLK) RESET_N = 1'b1;
        @(posedge CLK);
        #1 chk("post_rst_busy", 64'(bus.busy), 64'd0);
        run_op(OP_MUL, 32'd5, 32'd6, 32'd30, 33, 5'd18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
